// File: rtl/float_to_int_if.sv
// Request/result bundle for the float_to_int converter.
// The requester drives start/a; the converter returns the integer result,
// the completion pulse, the busy indication and the two status flags.
interface float_to_int_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] out;
  logic        done;
  logic        busy;
  logic        ovf;
  logic        inv;

  modport master (
    output start,
    output a,
    input  out,
    input  done,
    input  busy,
    input  ovf,
    input  inv
  );

  modport slave (
    input  start,
    input  a,
    output out,
    output done,
    output busy,
    output ovf,
    output inv
  );
endinterface

// File: rtl/float_to_int.sv
// IEEE-754 single-precision to signed 32-bit integer converter.
// Truncates toward zero. The 24-bit significand is aligned by a shifter
// that moves one bit per cycle, so latency depends on the exponent.
// NaN, infinity, zero/denormal, |x| < 1 and out-of-range values bypass the
// shifter and finish two edges after acceptance.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; operand captured on the accepting edge
// S_UNPACK | classify operand, load magnitude, shift direction and count
// S_SHIFT  | move magnitude one bit per cycle until the count is spent
// S_FINISH | apply sign or special result, update flags, pulse done
module float_to_int (
  input  logic          clk,
  input  logic          rst_n,
  float_to_int_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UNPACK = 2'd1,
    S_SHIFT  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0] r_a;
  logic [31:0] r_mag;
  logic [4:0]  r_cnt;
  logic        r_left;
  logic        r_sign;
  logic        r_special;
  logic [31:0] r_spec_val;
  logic        r_spec_ovf;
  logic        r_spec_inv;

  logic [31:0] r_out;
  logic        r_done;
  logic        r_ovf;
  logic        r_inv;

  logic        w_sign;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic [31:0] w_sat;
  logic        w_special;
  logic [31:0] w_spec_val;
  logic        w_spec_ovf;
  logic        w_spec_inv;
  logic        w_left;
  logic [4:0]  w_cnt;

  assign w_sign = r_a[31];
  assign w_exp  = r_a[30:23];
  assign w_frac = r_a[22:0];
  assign w_sat  = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;

  // The shifter is only used for 127 <= e <= 157, where |e-150| <= 23.
  // That distance fits in 5 bits, and 150 mod 32 = 22, so the low five
  // exponent bits are enough to form it without a wider subtract.
  assign w_left = (w_exp >= 8'd150);
  assign w_cnt  = w_left ? (w_exp[4:0] - 5'd22) : (5'd22 - w_exp[4:0]);

  // Classify the captured operand; non-special values fall through to the shifter.
  always_comb begin
    w_special  = 1'b1;
    w_spec_val = 32'h0000_0000;
    w_spec_ovf = 1'b0;
    w_spec_inv = 1'b0;
    if (w_exp == 8'd255) begin
      if (w_frac != 23'd0) begin
        w_spec_inv = 1'b1;
      end else begin
        w_spec_val = w_sat;
        w_spec_ovf = 1'b1;
      end
    end else if (w_exp == 8'd0) begin
      w_spec_val = 32'h0000_0000;
    end else if (w_exp < 8'd127) begin
      w_spec_val = 32'h0000_0000;
    end else if (w_exp >= 8'd158) begin
      // -2^31 is the one magnitude at E=31 that is still representable.
      if (w_sign && (w_exp == 8'd158) && (w_frac == 23'd0)) begin
        w_spec_val = 32'h8000_0000;
      end else begin
        w_spec_val = w_sat;
        w_spec_ovf = 1'b1;
      end
    end else begin
      w_special = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_UNPACK;
      S_UNPACK: w_state_nxt = w_special ? S_FINISH : S_SHIFT;
      S_SHIFT:  if (r_cnt == 5'd0) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, alignment datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= 32'h0000_0000;
      r_mag      <= 32'h0000_0000;
      r_cnt      <= 5'd0;
      r_left     <= 1'b0;
      r_sign     <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= 32'h0000_0000;
      r_spec_ovf <= 1'b0;
      r_spec_inv <= 1'b0;
      r_out      <= 32'h0000_0000;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_a <= bus.a;
        end
        S_UNPACK: begin
          r_sign     <= w_sign;
          r_special  <= w_special;
          r_spec_val <= w_spec_val;
          r_spec_ovf <= w_spec_ovf;
          r_spec_inv <= w_spec_inv;
          r_mag      <= {8'b0, 1'b1, w_frac};
          r_left     <= w_left;
          r_cnt      <= w_cnt;
        end
        S_SHIFT: begin
          if (r_cnt != 5'd0) begin
            r_mag <= r_left ? {r_mag[30:0], 1'b0} : {1'b0, r_mag[31:1]};
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_FINISH: begin
          if (r_special) begin
            r_out <= r_spec_val;
          end else begin
            r_out <= r_sign ? (~r_mag + 32'd1) : r_mag;
          end
          r_ovf  <= r_special & r_spec_ovf;
          r_inv  <= r_special & r_spec_inv;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = r_out;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
  assign bus.inv  = r_inv;
  assign bus.busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: conversion values, latency, flags,
// handshake behaviour and asynchronous reset.
module tb_float_to_int;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  float_to_int_if bus ();

  float_to_int dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one conversion and wait for done; checks latency, busy span,
  // result, flags and that done is a single-cycle pulse.
  task automatic run_conv(input string tag, input logic [31:0] av, input logic [31:0] eo,
                          input logic eovf, input logic einv, input int elat);
    int lat;
    int bc;
    lat = -1;
    bc  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    @(negedge clk);
    bus.start = 1'b0;
    bc += int'(bus.busy);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
      bc += int'(bus.busy);
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_out"}, bus.out, eo);
    check({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, eovf});
    check({tag, "_inv"}, {31'b0, bus.inv}, {31'b0, einv});
    check({tag, "_busy_cycles"}, bc, elat);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int lat;
    logic [31:0] seen;

    bus.start = 1'b0;
    bus.a     = 32'h0;

    #12;
    check("rst_out",  bus.out, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_ovf",  {31'b0, bus.ovf}, 32'd0);
    check("rst_inv",  {31'b0, bus.inv}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv("one",      32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 26);
    run_conv("m2p5",     32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 25);
    run_conv("large",    32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 10);
    run_conv("exact",    32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 3);
    run_conv("neg2p31",  32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
    run_conv("pos2p31",  32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2);
    run_conv("neginf",   32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2);
    run_conv("nan",      32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 2);
    run_conv("half",     32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 2);
    run_conv("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 2);
    run_conv("negzero",  32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2);

    // start while busy is ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h40A0_0000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h4120_0000;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    seen  = 32'hDEAD_BEEF;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        seen = bus.out;
      end
    end
    check("busy_start_ndone", ndone, 1);
    check("busy_start_out",   seen, 32'd5);

    // back-to-back: new start presented in the done cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h40A0_0000;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("b2b_first_lat", lat, 24);
    check("b2b_first_out", bus.out, 32'd5);
    bus.start = 1'b1;
    bus.a     = 32'h4120_0000;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_accept_busy", {31'b0, bus.busy}, 32'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("b2b_second_lat", lat, 23);
    check("b2b_second_out", bus.out, 32'd10);

    // reset in the middle of a shift
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h3F80_0000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_before_rst", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out",  bus.out, 32'h0);
    check("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);
    run_conv("after_rst", 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 26);

    // flags follow the latest conversion
    run_conv("flag_nan", 32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1, 2);
    run_conv("flag_one", 32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 26);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
